// File: rtl/isqrt_shared_arbiter_if.sv
// Requester-side bundle of isqrt_shared_arbiter.
// master: requester pool drives req/arg; slave: arbiter drives gnt/res_vld/res.
interface isqrt_shared_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int ARG_W = 32,
  parameter int RES_W = 16
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*ARG_W-1:0] arg;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       res_vld;
  logic [RES_W-1:0]       res;

  modport master (
    output req,
    output arg,
    input  gnt,
    input  res_vld,
    input  res
  );

  modport slave (
    input  req,
    input  arg,
    output gnt,
    output res_vld,
    output res
  );
endinterface

// File: rtl/isqrt_shared_arbiter.sv
// Shares one in-order integer sqrt unit among N_REQ requesters; a tag FIFO
// remembers who issued each argument so results are steered back.
// Ports: clk, rst (sync, active-high); rq (slave: req/arg in,
// gnt/res_vld/res out); isqrt_x_vld/isqrt_x to sqrt; isqrt_y_vld/isqrt_y
// from sqrt; busy (tags outstanding); err (sticky unexpected result).
// Define ISQRT_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module isqrt_shared_arbiter #(
  parameter int N_REQ = 3,
  parameter int ARG_W = 32,
  parameter int RES_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  isqrt_shared_arbiter_if.slave rq,
  output logic                 isqrt_x_vld,
  output logic [ARG_W-1:0]     isqrt_x,
  input  logic                 isqrt_y_vld,
  input  logic [RES_W-1:0]     isqrt_y,
  output logic                 busy,
  output logic                 err
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  cnt_t cnt_q, cnt_d;
  ptr_t wr_q, wr_d;
  ptr_t rd_q, rd_d;
  idx_t tag_q [DEPTH];

  logic found;
  idx_t sel;
  logic can_gnt;
  logic push;
  logic pop;

  logic [N_REQ-1:0] gnt_w;
  logic [N_REQ-1:0] res_vld_q, res_vld_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             x_vld_q;
  logic [ARG_W-1:0] x_q, x_d;
  logic             busy_q;
  logic             err_q, err_d;

`ifdef ISQRT_ARB_FIXED_PRIO_EN
  // Descending scan: the last hit is the lowest index.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rq.req[idx_t'(k)]) begin
        found = 1'b1;
        sel   = idx_t'(k);
      end
    end
  end
`else
  idx_t last_q, last_d;

  // Descending distance scan from last: the nearest
  // requester after last is written last and wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      int j;
      j = (int'(last_q) + k) % N_REQ;
      if (rq.req[idx_t'(j)]) begin
        found = 1'b1;
        sel   = idx_t'(j);
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (push) last_d = sel;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= idx_t'(N_REQ - 1);
    else     last_q <= last_d;
  end
`endif

  // A full FIFO never grants, even if a pop
  // frees a slot in the same cycle.
  always_comb begin
    can_gnt = cnt_q < cnt_t'(DEPTH);
    push    = found && can_gnt && !rst;
    pop     = isqrt_y_vld && (cnt_q != '0);
    gnt_w   = '0;
    if (push) gnt_w[sel] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + cnt_t'(1);
    else if (pop && !push) cnt_d = cnt_q - cnt_t'(1);
    wr_d = push ? wr_q + ptr_t'(1) : wr_q;
    rd_d = pop  ? rd_q + ptr_t'(1) : rd_q;
  end

  always_comb begin
    res_vld_d = '0;
    res_d     = res_q;
    if (pop) begin
      res_vld_d[tag_q[rd_q]] = 1'b1;
      res_d                  = isqrt_y;
    end
    x_d = x_q;
    if (push) x_d = rq.arg[int'(sel)*ARG_W +: ARG_W];
    // Result with nothing outstanding is dropped
    // and flagged until reset.
    err_d = err_q | (isqrt_y_vld & (cnt_q == '0));
  end

  // Tag storage needs no reset; pointers discard it.
  always_ff @(posedge clk) begin
    if (push) tag_q[wr_q] <= sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      res_vld_q <= '0;
      res_q     <= '0;
      x_vld_q   <= 1'b0;
      x_q       <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      res_vld_q <= res_vld_d;
      res_q     <= res_d;
      x_vld_q   <= push;
      x_q       <= x_d;
      busy_q    <= (cnt_d != '0);
      err_q     <= err_d;
    end
  end

  assign rq.gnt      = gnt_w;
  assign rq.res_vld  = res_vld_q;
  assign rq.res      = res_q;
  assign isqrt_x_vld = x_vld_q;
  assign isqrt_x     = x_q;
  assign busy        = busy_q;
  assign err         = err_q;
endmodule

// File: tb/tb_isqrt_shared_arbiter.sv
// Directed bench for isqrt_shared_arbiter with a pipelined sqrt model
// (latency 8) plus a manual result injector for protocol errors.
module tb_isqrt_shared_arbiter;
  localparam int L = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        isqrt_x_vld;
  logic [31:0] isqrt_x;
  logic        isqrt_y_vld;
  logic [15:0] isqrt_y;
  logic        busy;
  logic        err;
  logic        man_vld;
  logic [15:0] man_y;

  int checks = 0;
  int errors = 0;

  isqrt_shared_arbiter_if #(.N_REQ(3), .ARG_W(32), .RES_W(16)) bus ();

  isqrt_shared_arbiter #(
    .N_REQ(3), .ARG_W(32), .RES_W(16), .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rq(bus),
    .isqrt_x_vld(isqrt_x_vld),
    .isqrt_x(isqrt_x),
    .isqrt_y_vld(isqrt_y_vld),
    .isqrt_y(isqrt_y),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] isq(input logic [31:0] x);
    logic [15:0] r;
    logic [31:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = {16'd0, r | (16'd1 << b)};
      if (t * t <= x) r = t[15:0];
    end
    return r;
  endfunction

  logic [L-1:0] pv;
  logic [15:0]  pd [L];

  always @(posedge clk) begin
    if (rst) pv <= '0;
    else     pv <= {pv[L-2:0], isqrt_x_vld};
    pd[0] <= isq(isqrt_x);
    for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
  end

  assign isqrt_y_vld = pv[L-1] | man_vld;
  assign isqrt_y     = man_vld ? man_y : pd[L-1];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

`ifdef ISQRT_ARB_FIXED_PRIO_EN
  logic [2:0]  eg [4] = '{3'b001, 3'b001, 3'b001, 3'b001};
  logic [15:0] er [4] = '{16'd3, 16'd3, 16'd3, 16'd3};
`else
  logic [2:0]  eg [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [15:0] er [4] = '{16'd3, 16'd5, 16'd10, 16'd3};
`endif

  logic [3:0] mx;

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.arg = '0;
    man_vld = 1'b0;
    man_y = '0;
    repeat (2) cyc();
    bus.req = 3'b001;
    #1 check("gnt_in_rst", bus.gnt, 3'b000);
    bus.req = '0;
    cyc();
    check("rst_res_vld", bus.res_vld, 3'b000);
    check("rst_res", bus.res, 16'd0);
    check("rst_x_vld", isqrt_x_vld, 1'b0);
    check("rst_x", isqrt_x, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_cnt", dut.cnt_q, 3'd0);
    rst = 1'b0;

    // Single request, N = this cycle.
    cyc();
    bus.req = 3'b001;
    bus.arg = {32'd0, 32'd0, 32'd16};
    #1 check("single_gnt", bus.gnt, 3'b001);
    cyc();
    bus.req = '0;
    #1 check("single_x_vld", isqrt_x_vld, 1'b1);
    check("single_x", isqrt_x, 32'd16);
    check("single_gnt_off", bus.gnt, 3'b000);
    check("single_busy", busy, 1'b1);
    repeat (L) cyc();
    check("single_early", bus.res_vld, 3'b000);
    check("single_busy_hold", busy, 1'b1);
    cyc();
    check("single_res_vld", bus.res_vld, 3'b001);
    check("single_res", bus.res, 16'd4);
    check("single_busy_end", busy, 1'b0);
    cyc();
    check("single_strobe_1cyc", bus.res_vld, 3'b000);

    // Fairness from a fresh reset.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.req = 3'b111;
    bus.arg = {32'd100, 32'd25, 32'd9};
    for (int i = 0; i < 4; i++) begin
      #1 check("fair_gnt", bus.gnt, eg[i]);
      cyc();
      if (i == 0) check("fair_x0", isqrt_x, 32'd9);
    end
    #1 check("fair_full_gnt", bus.gnt, 3'b000);
    check("fair_full_cnt", dut.cnt_q, 3'd4);
    bus.req = '0;
    repeat (6) cyc();
    for (int i = 0; i < 4; i++) begin
      check("fair_res_vld", bus.res_vld, eg[i]);
      check("fair_res", bus.res, er[i]);
      cyc();
    end
    check("fair_busy_end", busy, 1'b0);
    check("fair_res_idle", bus.res_vld, 3'b000);

    // FIFO full with requester 0 held.
    bus.req = 3'b001;
    bus.arg = {32'd0, 32'd0, 32'd49};
    mx = '0;
    for (int k = 0; k < 15; k++) begin
      #1 check("full_gnt", bus.gnt,
               (k < 4 || (k >= 10 && k <= 13)) ? 3'b001 : 3'b000);
      if (k == 8) check("full_y_pre", isqrt_y_vld, 1'b0);
      if (k == 9) check("full_y_pop", isqrt_y_vld, 1'b1);
      if (k == 10) begin
        check("full_res_vld", bus.res_vld, 3'b001);
        check("full_res", bus.res, 16'd7);
      end
      if ({1'b0, dut.cnt_q} > mx) mx = {1'b0, dut.cnt_q};
      cyc();
    end
    check("full_max_cnt", mx, 4'd4);
    bus.req = '0;
    repeat (10) cyc();
    check("full_drain_busy", busy, 1'b0);

    // Simultaneous push and pop at cnt=2.
    bus.req = 3'b001;
    bus.arg = {32'd0, 32'd0, 32'd64};
    #1 check("pp_gnt0", bus.gnt, 3'b001);
    cyc();
    bus.req = 3'b010;
    bus.arg = {32'd0, 32'd81, 32'd64};
    #1 check("pp_gnt1", bus.gnt, 3'b010);
    cyc();
    bus.req = '0;
    repeat (7) cyc();
    bus.req = 3'b100;
    bus.arg = {32'd144, 32'd81, 32'd64};
    #1 check("pp_cnt_before", dut.cnt_q, 3'd2);
    check("pp_gnt2", bus.gnt, 3'b100);
    check("pp_y_vld", isqrt_y_vld, 1'b1);
    cyc();
    bus.req = '0;
    check("pp_cnt_after", dut.cnt_q, 3'd2);
    check("pp_res_vld0", bus.res_vld, 3'b001);
    check("pp_res0", bus.res, 16'd8);
    check("pp_x_vld", isqrt_x_vld, 1'b1);
    check("pp_x", isqrt_x, 32'd144);
    cyc();
    check("pp_res_vld1", bus.res_vld, 3'b010);
    check("pp_res1", bus.res, 16'd9);
    repeat (8) cyc();
    check("pp_res_vld2", bus.res_vld, 3'b100);
    check("pp_res2", bus.res, 16'd12);
    cyc();
    check("pp_busy_end", busy, 1'b0);

    // Unexpected result with empty FIFO.
    man_vld = 1'b1;
    man_y = 16'd5;
    cyc();
    man_vld = 1'b0;
    check("perr_err", err, 1'b1);
    check("perr_no_res", bus.res_vld, 3'b000);
    cyc();
    check("perr_sticky", err, 1'b1);
    check("perr_no_res2", bus.res_vld, 3'b000);
    rst = 1'b1;
    cyc();
    check("perr_rst_clear", err, 1'b0);
    rst = 1'b0;

    // Reset with three outstanding.
    bus.req = 3'b111;
    bus.arg = {32'd9, 32'd4, 32'd1};
    #1 check("mid_gnt0", bus.gnt, 3'b001);
    repeat (3) cyc();
    check("mid_cnt3", dut.cnt_q, 3'd3);
    bus.req = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mid_gnt", bus.gnt, 3'b000);
    check("mid_res_vld", bus.res_vld, 3'b000);
    check("mid_res", bus.res, 16'd0);
    check("mid_x_vld", isqrt_x_vld, 1'b0);
    check("mid_x", isqrt_x, 32'd0);
    check("mid_busy", busy, 1'b0);
    check("mid_err", err, 1'b0);
    check("mid_cnt", dut.cnt_q, 3'd0);
    bus.req = 3'b010;
    bus.arg = {32'd0, 32'hFFFF_FFFF, 32'd0};
    #1 check("post_gnt", bus.gnt, 3'b010);
    cyc();
    bus.req = '0;
    repeat (8) cyc();
    check("post_early", bus.res_vld, 3'b000);
    cyc();
    check("post_res_vld", bus.res_vld, 3'b010);
    check("post_res", bus.res, 16'd65535);
    cyc();
    check("post_err", err, 1'b0);
    check("post_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/isqrt_shared_arbiter.md
# isqrt_shared_arbiter

Shares one integer square-root unit (valid-only, in-order, no backpressure; `x_vld`/`x` in, `y_vld`/`y` out) among `N_REQ` requesters, e.g. the three sqrt lanes of the formula FSMs. Issues at most one argument per cycle, round-robin by default. Records the requester index of every issued argument in a tag FIFO. Steers each returning result back to its requester.

## Interface
- `N_REQ`, default 3: number of requesters (2..8).
- `ARG_W`, default 32: argument width.
- `RES_W`, default 16: result width.
- `DEPTH`, default 4: tag FIFO depth, which is the maximum number of outstanding requests (power of two, ≥2).

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset. One clock; reset is synchronous and active-high.
- `req`  in  N_REQ: per-requester request, held until granted.
- `arg`  in  N_REQ*ARG_W: requester i argument at `[i*ARG_W +: ARG_W]`, stable while `req[i]`.
- `gnt`  out  N_REQ: one-hot grant, combinational, at most one bit set.
- `res_vld`  out  N_REQ: one-hot result strobe, registered, one cycle wide.
- `res`  out  RES_W: result for the requester flagged in `res_vld`, registered.
- `isqrt_x_vld`  out  1: argument valid to the sqrt unit, registered.
- `isqrt_x`  out  ARG_W: argument to the sqrt unit, registered.
- `isqrt_y_vld`  in  1: result valid from the sqrt unit.
- `isqrt_y`  in  RES_W: result from the sqrt unit.
- `busy`  out  1: tag FIFO non-empty, registered.
- `err`  out  1: sticky protocol error, registered.

## Operation
- **Grant eligibility.** A grant may issue only when `cnt < DEPTH`.
  - `cnt` is the FIFO occupancy, 0..DEPTH, in `$clog2(DEPTH)+1` bits.
- **Round-robin.** The search starts at `(last+1) mod N_REQ` and grants the first requester with `req` set. `last` updates to the granted index.
- **Grant effects.** A grant to i in cycle N does three things:
  - pushes tag i into the FIFO;
  - registers `isqrt_x <= arg[i]`;
  - asserts `isqrt_x_vld` in N+1.
- **Requester handshake.** A requester seeing `gnt[i]` may drop `req[i]` or present a new `arg` next cycle.
- **Result return.** `isqrt_y_vld` in cycle M pops the head tag t. In M+1, `res_vld[t]=1` and `res=isqrt_y`.
- **Push and pop together.** A simultaneous push and pop leaves `cnt` unchanged; both complete.
  - A full FIFO does not grant, even when a pop occurs in the same cycle.
- **Unexpected result.** `isqrt_y_vld` with an empty FIFO:
  - the result is dropped and no `res_vld` is raised;
  - `err` is set and stays 1 until `rst`.
- **No sqrt gating.** The block never stalls the sqrt unit. An in-order, lossless sqrt unit guarantees tag/result pairing.
- **Widths.** No arithmetic beyond the `cnt`, pointer and `last` counters. Pointers wrap modulo DEPTH; `last` wraps modulo N_REQ.

## Timing
- **Reset values.**
  - `gnt=0`, `res_vld=0`, `res=0`, `isqrt_x_vld=0`, `isqrt_x=0`, `busy=0`, `err=0`.
  - `cnt=0`, FIFO pointers 0, `last=N_REQ-1`, so requester 0 wins first.
- **Grants during reset.** `gnt` is forced to 0 while `rst=1`.
- **Reset mid-operation.** All outstanding tags are discarded.
  - The sqrt unit must share `rst`.
  - A result arriving after reset with an empty FIFO sets `err`.
- **Latency.** Grant to `res_vld` = L + 2 cycles, where L is the sqrt latency from `x_vld` to `y_vld`.
- **Throughput.** One grant per cycle while `cnt < DEPTH`.
  - Sustained rate with a pipelined sqrt needs `DEPTH ≥ L+2`.
- **`busy` timing.** `busy` reflects `cnt != 0` as of the previous edge.

## Configuration
- **`ISQRT_ARB_FIXED_PRIO_EN` defined:** fixed priority, lowest index wins; `last` is unused.
- **Undefined (default):** round-robin as in Operation.
- **Unaffected:** all other behaviour, timing and reset values.

## Test plan
- **Single request.** Reset; `req=001`, `arg0=16` for 1 cycle.
  - `gnt=001` at once; `isqrt_x_vld` with `isqrt_x=16` next cycle.
  - Exactly L+2 cycles after the grant, `res_vld=001`, `res=4`; `busy` returns to 0.
- **Fairness.** All three held, `arg=9,25,100`, pipelined sqrt.
  - Grants 001, 010, 100, 001… in consecutive cycles.
  - Results 3, 5, 10 arrive on `res_vld` 001, 010, 100 in issue order.
  - With the macro defined, requester 0 is granted every cycle and 1/2 starve.
- **FIFO full.** DEPTH=4, sqrt L=8, `req` held on requester 0.
  - Exactly 4 grants, then `gnt=0` until the first `isqrt_y_vld`.
  - The cycle after that pop, one new grant issues; `cnt` never exceeds 4.
- **Simultaneous push and pop.** `cnt=2`, grant and `isqrt_y_vld` in the same cycle.
  - `cnt` stays 2; the popped tag's result and the new argument are both correct.
- **Protocol error.** `isqrt_y_vld` pulsed with an empty FIFO.
  - `err` goes 1 next cycle and stays 1; no `res_vld`.
  - `rst` clears `err`.
- **Reset mid-flight.** `rst` with 3 outstanding.
  - All outputs go to 0 next cycle and `cnt=0`.
  - A subsequent request with `arg=0xFFFFFFFF` returns `res=65535` to the right requester.
